// File: rtl/relu_maxpool_stream.sv
// relu_maxpool_stream
//   Streaming ReLU followed by 2x2 / stride-2 max-pool over a 2-channel
//   raster-ordered feature map. Both channels travel together on each beat.
//   Storage is one hold register per channel, which carries the even-column
//   pixel, and one half-width line buffer per channel, which carries the
//   even-row pair maxima. No full frame is ever stored.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input beat valid
//   in_ready   stage can accept a beat (= !out_valid || out_ready)
//   in_data0   channel-0 pixel, signed
//   in_data1   channel-1 pixel, signed
//   out_valid  pooled beat valid
//   out_ready  consumer accepts pooled beat
//   out_data0  channel-0 pooled value (>= 0)
//   out_data1  channel-1 pooled value (>= 0)
//   out_last   final pooled beat of the frame
module relu_maxpool_stream #(
  parameter int BITWIDTH = 16,
  parameter int IN_ROWS  = 10,
  parameter int IN_COLS  = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITWIDTH-1:0] in_data0,
  input  logic signed [BITWIDTH-1:0] in_data1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BITWIDTH-1:0] out_data0,
  output logic signed [BITWIDTH-1:0] out_data1,
  output logic                       out_last
);

  localparam int HALF = IN_COLS / 2;
  localparam int RW   = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int CW   = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [LW-1:0] lb_idx;
  logic          in_xfer;
  logic          out_xfer;
  logic          last_col;
  logic          last_row;

  logic signed [BITWIDTH-1:0] h0, h1;
  logic signed [BITWIDTH-1:0] r0, r1;
  logic signed [BITWIDTH-1:0] hm0, hm1;
  logic signed [BITWIDTH-1:0] lb0_rd, lb1_rd;
  logic signed [BITWIDTH-1:0] pm0, pm1;

  // Line buffers hold max of each horizontal pair from the even row,
  // indexed by pooled column. No reset: every entry is written on the
  // even row before the odd row reads it.
  logic signed [BITWIDTH-1:0] linebuf0 [HALF];
  logic signed [BITWIDTH-1:0] linebuf1 [HALF];

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign last_col = (col == CW'(IN_COLS - 1));
  assign last_row = (row == RW'(IN_ROWS - 1));
  assign lb_idx   = LW'(col >> 1);
  assign lb0_rd   = linebuf0[lb_idx];
  assign lb1_rd   = linebuf1[lb_idx];

  // ReLU, then signed max. After ReLU every operand is >= 0, so the
  // comparisons can never see a wrapped value and no widening is needed.
  always_comb begin
    r0  = in_data0[BITWIDTH-1] ? '0 : in_data0;
    r1  = in_data1[BITWIDTH-1] ? '0 : in_data1;
    hm0 = (h0 > r0) ? h0 : r0;
    hm1 = (h1 > r1) ? h1 : r1;
    pm0 = (lb0_rd > hm0) ? lb0_rd : hm0;
    pm1 = (lb1_rd > hm1) ? lb1_rd : hm1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      h0        <= '0;
      h1        <= '0;
      out_valid <= 1'b0;
      out_data0 <= '0;
      out_data1 <= '0;
      out_last  <= 1'b0;
    end else begin
      // Drain first; a reload in the same cycle overrides it below.
      if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (in_xfer) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        if (!col[0]) begin
          h0 <= r0;
          h1 <= r1;
        end else if (row[0]) begin
          out_data0 <= pm0;
          out_data1 <= pm1;
          out_valid <= 1'b1;
          out_last  <= last_row && last_col;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && in_xfer && col[0] && !row[0]) begin
      linebuf0[lb_idx] <= hm0;
      linebuf1[lb_idx] <= hm1;
    end
  end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
module tb_relu_maxpool_stream;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data0;
  logic signed [15:0] in_data1;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data0;
  logic signed [15:0] out_data1;
  logic               out_last;

  int total = 0;
  int bad   = 0;
  int in_cnt = 0;

  logic signed [15:0] q0 [$];
  logic signed [15:0] q1 [$];
  logic               ql [$];

  // 2x6 corner used by the signed-max test (rows 0..1, cols 0..5)
  int win0 [12] = '{-5, 3, -7, -9, 9, 4, -32768, 2, -1, -2, 2, 8};
  int win1 [12] = '{-1, -2, -100, 5, 1, 2, -3, -4, 32767, 6, 20, 3};

  relu_maxpool_stream #(.BITWIDTH(16), .IN_ROWS(10), .IN_COLS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge sees exactly what the next
  // posedge will act on.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        q0.push_back(out_data0);
        q1.push_back(out_data1);
        ql.push_back(out_last);
      end
      if (in_valid && in_ready) in_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [15:0] pix(input int mode, input int r, input int c, input int ch);
    int v;
    case (mode)
      0:       v = (ch == 0) ? (r * 10 + c) : -(r * 10 + c);
      1:       v = (r < 2 && c < 6) ? ((ch == 0) ? win0[r*6+c] : win1[r*6+c]) : 0;
      2:       v = 1;
      default: v = 7;
    endcase
    return 16'(v);
  endfunction

  task automatic send_beat(input logic signed [15:0] d0, input logic signed [15:0] d1, input bit rnd);
    int n;
    n = 0;
    if (rnd) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data0 = d0;
    in_data1 = d1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (n > 1000) begin
        total++; bad++;
        $display("FAIL send_beat timeout got in_ready=0 want in_ready=1");
        break;
      end
    end
    in_valid = 1'b0;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input int mode, input bit rnd);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        send_beat(pix(mode, r, c, 0), pix(mode, r, c, 1), rnd);
  endtask

  task automatic wait_outputs(input int n);
    int cnt;
    cnt = 0;
    out_ready = 1'b1;
    while (q0.size() < n && cnt < 1000) begin
      @(posedge clk);
      cnt++;
    end
    total++;
    if (q0.size() < n) begin
      bad++;
      $display("FAIL wait_outputs timeout got=%0d want=%0d", q0.size(), n);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data0  = 16'sd5;
    in_data1  = 16'sd6;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data0 !== 16'sd0) begin bad++; $display("FAIL reset_out_data0 got=%0d want=0", out_data0); end
    total++; if (out_data1 !== 16'sd0) begin bad++; $display("FAIL reset_out_data1 got=%0d want=0", out_data1); end
    total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_known_frame();
    int b, e0;
    b = q0.size();
    out_ready = 1'b1;
    send_frame(0, 1'b0);
    wait_outputs(b + 25);
    total++; if (q0.size() - b != 25) begin bad++; $display("FAIL known_count got=%0d want=25", q0.size() - b); end
    for (int i = 0; i < 25 && b + i < q0.size(); i++) begin
      e0 = (2 * (i / 5) + 1) * 10 + 2 * (i % 5) + 1;
      total++;
      if (q0[b+i] !== 16'(e0) || q1[b+i] !== 16'sd0 || ql[b+i] !== (i == 24)) begin
        bad++;
        $display("FAIL known[%0d] got ch0=%0d ch1=%0d last=%b want ch0=%0d ch1=0 last=%b",
                 i, q0[b+i], q1[b+i], ql[b+i], e0, (i == 24));
      end
    end
  endtask

  task automatic test_signed_max();
    int b, e0, e1;
    b = q0.size();
    out_ready = 1'b1;
    send_frame(1, 1'b0);
    wait_outputs(b + 25);
    total++; if (q0.size() - b != 25) begin bad++; $display("FAIL signed_count got=%0d want=25", q0.size() - b); end
    for (int i = 0; i < 25 && b + i < q0.size(); i++) begin
      e0 = (i == 0) ? 3 : (i == 2) ? 9 : 0;
      e1 = (i == 1) ? 32767 : (i == 2) ? 20 : 0;
      total++;
      if (q0[b+i] !== 16'(e0) || q1[b+i] !== 16'(e1)) begin
        bad++;
        $display("FAIL signed[%0d] got ch0=%0d ch1=%0d want ch0=%0d ch1=%0d", i, q0[b+i], q1[b+i], e0, e1);
      end
    end
  endtask

  task automatic test_backpressure();
    int b, ib, e0;
    b  = q0.size();
    ib = in_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_beat(pix(0, i / 10, i % 10, 0), pix(0, i / 10, i % 10, 1), 1'b0);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_early_valid got=%b want=0", out_valid); end
    @(posedge clk); #1;
    send_beat(pix(0, 1, 1, 0), pix(0, 1, 1, 1), 1'b0);
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data0 !== 16'sd11 || out_data1 !== 16'sd0) begin
      bad++; $display("FAIL bp_latency got valid=%b ch0=%0d ch1=%0d want valid=1 ch0=11 ch1=0", out_valid, out_data0, out_data1);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data0 = pix(0, 1, 2, 0);
    in_data1 = pix(0, 1, 2, 1);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data0 !== 16'sd11) begin
        bad++; $display("FAIL bp_stall got in_ready=%b valid=%b ch0=%0d want in_ready=0 valid=1 ch0=11", in_ready, out_valid, out_data0);
      end
    end
    total++; if (in_cnt - ib != 12) begin bad++; $display("FAIL bp_consumed got=%0d want=12", in_cnt - ib); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_resume got in_ready=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_cnt - ib != 13 || q0.size() - b != 1) begin
      bad++; $display("FAIL bp_after_drain got in=%0d out=%0d want in=13 out=1", in_cnt - ib, q0.size() - b);
    end
    @(posedge clk); #1;
    for (int i = 13; i < 100; i++) send_beat(pix(0, i / 10, i % 10, 0), pix(0, i / 10, i % 10, 1), 1'b0);
    wait_outputs(b + 25);
    total++; if (q0.size() - b != 25) begin bad++; $display("FAIL bp_count got=%0d want=25", q0.size() - b); end
    for (int i = 0; i < 25 && b + i < q0.size(); i++) begin
      e0 = (2 * (i / 5) + 1) * 10 + 2 * (i % 5) + 1;
      total++;
      if (q0[b+i] !== 16'(e0) || q1[b+i] !== 16'sd0 || ql[b+i] !== (i == 24)) begin
        bad++;
        $display("FAIL bp[%0d] got ch0=%0d ch1=%0d last=%b want ch0=%0d ch1=0 last=%b",
                 i, q0[b+i], q1[b+i], ql[b+i], e0, (i == 24));
      end
    end
  endtask

  task automatic test_random();
    int b, e0;
    b = q0.size();
    send_frame(0, 1'b1);
    wait_outputs(b + 25);
    total++; if (q0.size() - b != 25) begin bad++; $display("FAIL rand_count got=%0d want=25", q0.size() - b); end
    for (int i = 0; i < 25 && b + i < q0.size(); i++) begin
      e0 = (2 * (i / 5) + 1) * 10 + 2 * (i % 5) + 1;
      total++;
      if (q0[b+i] !== 16'(e0) || q1[b+i] !== 16'sd0 || ql[b+i] !== (i == 24)) begin
        bad++;
        $display("FAIL rand[%0d] got ch0=%0d ch1=%0d last=%b want ch0=%0d ch1=0 last=%b",
                 i, q0[b+i], q1[b+i], ql[b+i], e0, (i == 24));
      end
    end
  endtask

  task automatic test_reset_mid();
    int b, e0;
    out_ready = 1'b1;
    for (int i = 0; i < 37; i++) send_beat(pix(0, i / 10, i % 10, 0), pix(0, i / 10, i % 10, 1), 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_state got valid=%b in_ready=%b want valid=0 in_ready=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    b = q0.size();
    send_frame(0, 1'b0);
    wait_outputs(b + 25);
    total++; if (q0.size() - b != 25) begin bad++; $display("FAIL midrst_count got=%0d want=25", q0.size() - b); end
    for (int i = 0; i < 25 && b + i < q0.size(); i++) begin
      e0 = (2 * (i / 5) + 1) * 10 + 2 * (i % 5) + 1;
      total++;
      if (q0[b+i] !== 16'(e0) || q1[b+i] !== 16'sd0 || ql[b+i] !== (i == 24)) begin
        bad++;
        $display("FAIL midrst[%0d] got ch0=%0d ch1=%0d last=%b want ch0=%0d ch1=0 last=%b",
                 i, q0[b+i], q1[b+i], ql[b+i], e0, (i == 24));
      end
    end
  endtask

  task automatic test_back_to_back();
    int b, e0;
    time t0, t1;
    b = q0.size();
    out_ready = 1'b1;
    t0 = $time;
    send_frame(2, 1'b0);
    send_frame(3, 1'b0);
    send_frame(2, 1'b0);
    t1 = $time;
    total++; if ((t1 - t0) / 10 != 300) begin bad++; $display("FAIL b2b_cycles got=%0d want=300", (t1 - t0) / 10); end
    wait_outputs(b + 75);
    total++; if (q0.size() - b != 75) begin bad++; $display("FAIL b2b_count got=%0d want=75", q0.size() - b); end
    for (int i = 0; i < 75 && b + i < q0.size(); i++) begin
      e0 = (i / 25 == 1) ? 7 : 1;
      total++;
      if (q0[b+i] !== 16'(e0) || q1[b+i] !== 16'(e0) || ql[b+i] !== (i % 25 == 24)) begin
        bad++;
        $display("FAIL b2b[%0d] got ch0=%0d ch1=%0d last=%b want ch0=%0d ch1=%0d last=%b",
                 i, q0[b+i], q1[b+i], ql[b+i], e0, e0, (i % 25 == 24));
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_frame();
    test_signed_max();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
